// File: rtl/jarvis_pkg.sv
// Shared types and constants for the instruction fetch front end.
package jarvis_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int IMEM_WORD_SHIFT  = 2;
  localparam int FETCH_FIFO_DEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry output buffer of {pc, instr}; head is always entry 0.
module fetch_fifo
  import jarvis_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t din,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t e0, e1;

  // Callers never push into a full buffer or pop an empty one.
  // On a pop that empties the buffer, e0 is left alone so the last head stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) e0 <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            e0 <= e1;
            e1 <= din;
          end else begin
            e0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = e0;

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: PC, credit-based issue into a registered-read instr_mem, redirect flush.
module instr_fetch
  import jarvis_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  logic [31:0]  pc, infl_pc;
  logic         infl;
  logic [1:0]   count;
  logic [2:0]   level;
  logic         pop, push, issue;
  fetch_entry_t din, head;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Credit: buffered + in flight - leaving this cycle must leave room for one more.
  assign level = {1'b0, count} + {2'b00, infl} - {2'b00, pop};
  assign issue = !redirect_valid && (level < 3'(FIFO_DEPTH));
  assign push  = infl && !redirect_valid;

  assign din       = '{pc: infl_pc, instr: imem_data};
  assign imem_addr = pc >> IMEM_WORD_SHIFT;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      infl    <= 1'b0;
      infl_pc <= '0;
    end else if (redirect_valid) begin
      pc   <= redirect_pc & ~32'h3;
      infl <= 1'b0;
    end else begin
      infl <= issue;
      if (issue) begin
        infl_pc <= pc;
        pc      <= pc + 32'd4;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .count (count),
    .head  (head)
  );

endmodule
